reg_seq_ctrl: RTL and testbench
===============================

Name: reg_seq_ctrl

Overview:
Multi-cycle control sequencer for the 8-bit core. It fetches one instruction per pass over an instruction-memory handshake, then decodes it. It drives the read/write selects and write enable of the 4x8 register file, and sequences the ALU, data-memory and PC update. It sits between the memories and the register-file/ALU datapath, and supports a run/stop control and an ack-timeout fault.

Parameters:
TIMEOUT, 15, max cycles waiting for imem_ack/dmem_ack before FAULT; 0 disables timeout
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
run  input  1  1 = start/continue fetching; sampled in IDLE and at end of each instruction
imem_req  output  1  instruction fetch request, held until ack
imem_ack  input  1  fetch data valid this cycle
imem_data  input  8  instruction word
dmem_req  output  1  data access request, held until ack
dmem_we  output  1  1 = store, valid while dmem_req
dmem_ack  input  1  data access complete
alu_zero  input  1  ALU result == 0 (datapath computes rs-rt during BEQ EXEC)
readReg1  output  2  register-file read select 1
readReg2  output  2  register-file read select 2
writeReg  output  2  register-file write select
sigRegWrite  output  1  register-file write enable
alu_op  output  1  0 = add, 1 = subtract
alu_src_imm  output  1  1 = ALU B from sign-extended IR[1:0]
wb_sel  output  1  0 = ALU result, 1 = dmem read data
pc_inc  output  1  one-cycle PC+1 pulse
pc_branch  output  1  one-cycle PC += sext(IR[1:0]) pulse
busy  output  1  1 in any state except IDLE and FAULT
fault  output  1  sticky timeout indication
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE; IR=0; timeout counter=0; instr_count=0. All outputs 0. readReg1/readReg2/writeReg decode from IR=0, so they read 0.
- Instruction format: IR[7:6]=op, IR[5:4]=rs, IR[3:2]=rt, IR[1:0]=rd/imm2. Opcodes:
  - 00 ADD: rd <= rs + rt.
  - 01 LW: rt <= mem[rs + sext(imm2)].
  - 10 SW: mem[rs + sext(imm2)] <= rt.
  - 11 BEQ: if rs == rt, branch by sext(imm2).
- readReg1=IR[5:4] and readReg2=IR[3:2] at all times. writeReg=IR[1:0] for ADD, IR[3:2] otherwise.
- States and transitions:
  - IDLE: exit to FETCH when run=1.
  - FETCH: imem_req=1. On imem_ack, latch IR=imem_data and go to DECODE.
  - DECODE: 1 cycle; pc_inc=1. Go to EXEC.
  - EXEC: 1 cycle.
    - ADD: alu_op=0, alu_src_imm=0; go to WB.
    - LW/SW: alu_op=0, alu_src_imm=1; go to MEM.
    - BEQ: alu_op=1, alu_src_imm=0; pc_branch=alu_zero. Retire; go to FETCH if run else IDLE.
  - MEM: dmem_req=1, dmem_we=(op==SW), alu_src_imm=1.
    - On dmem_ack: SW retires (go to FETCH if run else IDLE); LW goes to WB.
  - WB: sigRegWrite=1 for exactly 1 cycle; wb_sel=(op==LW). Retire; go to FETCH if run else IDLE.
  - FAULT: all requests 0, fault=1. Only reset exits.
- Retire: instr_count+1 on the cycle the instruction completes (BEQ EXEC, SW ack, WB).
- run=0 mid-instruction: the current instruction completes; the next FETCH is not entered.
- Timeout counter: cleared on entry to FETCH/MEM, incremented each waiting cycle without ack.
  - When the counter reaches TIMEOUT with no ack, go to FAULT on the next edge.
  - An ack in the same cycle the counter reaches TIMEOUT wins: no fault.
- sigRegWrite is never asserted outside WB; pc_inc and pc_branch are never asserted together.
- Reset mid-operation aborts immediately; no write or PC pulse completes.

Test Plan:
- Reset then run=1; imem_ack same cycle as req with 0x1B (ADD r1,r2->r3) -> DECODE pc_inc; EXEC alu_op=0; WB sigRegWrite=1, writeReg=3, wb_sel=0; instr_count=1; total 4 cycles.
- LW 0x46 (rs=0, rt=1, imm=-2), dmem_ack after 3 cycles -> dmem_req held 3 cycles, dmem_we=0; then WB writeReg=1, wb_sel=1, sigRegWrite for 1 cycle.
- SW 0x85 -> dmem_we=1 while dmem_req; no sigRegWrite ever; retires on ack, count+1.
- BEQ 0xF1: with alu_zero=1 -> pc_inc in DECODE, pc_branch in EXEC; with alu_zero=0 -> no pc_branch; no register write in either case.
- TIMEOUT=15, imem_ack held 0 -> fault=1 and busy=0 after the timeout; requests dropped; stays in FAULT until reset=0. Separately, ack on the 15th wait cycle -> no fault.
- run dropped during the MEM wait of an LW -> LW completes through WB, then IDLE with imem_req=0; reset=0 asserted during WB -> sigRegWrite drops to 0 immediately.

Source files
------------

// File: rtl/reg_seq_ctrl_if.sv
// Instruction- and data-memory request/acknowledge handshake between the
// sequencer (master) and the memory subsystem (slave).
interface reg_seq_ctrl_if;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_data, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_data, dmem_ack
  );
endinterface

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit core: fetch, decode, execute,
// memory and write-back phases with a run/stop control and an ack-timeout fault.
module reg_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  reg_seq_ctrl_if.master     mem,
  input  logic               alu_zero,
  output logic [1:0]         readReg1,
  output logic [1:0]         readReg2,
  output logic [1:0]         writeReg,
  output logic               sigRegWrite,
  output logic               alu_op,
  output logic               alu_src_imm,
  output logic               wb_sel,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic               busy,
  output logic               fault,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    FAULT
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [7:0]       ir;
  logic [1:0]       op;
  logic [TO_W-1:0]  waitCnt;
  logic             waiting;
  logic             timedOut;
  logic             retire;

  assign op       = ir[7:6];
  assign readReg1 = ir[5:4];
  assign readReg2 = ir[3:2];
  assign writeReg = (op == OP_ADD) ? ir[1:0] : ir[3:2];
  assign busy     = (state != IDLE) && (state != FAULT);
  assign timedOut = (TIMEOUT != 0) && (waitCnt == TO_W'(TIMEOUT));

  // An ack arriving in the same cycle the wait counter hits TIMEOUT takes
  // priority over the fault transition.
  always_comb begin
    nextState    = state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    sigRegWrite  = 1'b0;
    alu_op       = 1'b0;
    alu_src_imm  = 1'b0;
    wb_sel       = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    fault        = 1'b0;
    waiting      = 1'b0;
    retire       = 1'b0;
    case (state)
      IDLE: begin
        if (run) nextState = FETCH;
      end
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          nextState = DECODE;
        end else begin
          waiting = 1'b1;
          if (timedOut) nextState = FAULT;
        end
      end
      DECODE: begin
        pc_inc    = 1'b1;
        nextState = EXEC;
      end
      EXEC: begin
        case (op)
          OP_ADD: nextState = WB;
          OP_LW, OP_SW: begin
            alu_src_imm = 1'b1;
            nextState   = MEM;
          end
          default: begin
            alu_op    = 1'b1;
            pc_branch = alu_zero;
            retire    = 1'b1;
            nextState = run ? FETCH : IDLE;
          end
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (op == OP_SW);
        alu_src_imm  = 1'b1;
        if (mem.dmem_ack) begin
          if (op == OP_SW) begin
            retire    = 1'b1;
            nextState = run ? FETCH : IDLE;
          end else begin
            nextState = WB;
          end
        end else begin
          waiting = 1'b1;
          if (timedOut) nextState = FAULT;
        end
      end
      WB: begin
        sigRegWrite = 1'b1;
        wb_sel      = (op == OP_LW);
        retire      = 1'b1;
        nextState   = run ? FETCH : IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= 8'h00;
    end else if (state == FETCH && mem.imem_ack) begin
      ir <= mem.imem_data;
    end
  end

  // Any state change restarts the wait count, so each FETCH or MEM visit
  // gets its own full timeout window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (state != nextState) begin
      waitCnt <= '0;
    end else if (waiting && TIMEOUT != 0) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Scoreboard bench for reg_seq_ctrl: memory responder with programmable ack
// delays, expected write-backs and retire counts queued at stimulus time.
module tb_reg_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       alu_zero;
  logic [1:0] readReg1;
  logic [1:0] readReg2;
  logic [1:0] writeReg;
  logic       sigRegWrite;
  logic       alu_op;
  logic       alu_src_imm;
  logic       wb_sel;
  logic       pc_inc;
  logic       pc_branch;
  logic       busy;
  logic       fault;
  logic [7:0] instr_count;

  reg_seq_ctrl_if bus ();

  reg_seq_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem         (bus),
    .alu_zero    (alu_zero),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .writeReg    (writeReg),
    .sigRegWrite (sigRegWrite),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .wb_sel      (wb_sel),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .busy        (busy),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int modelCount = 0;

  logic [7:0] expCountQ[$];
  logic [2:0] expWrQ[$];
  logic [2:0] obsWrQ[$];
  logic [7:0] expCount;
  logic [2:0] expWr;
  logic [2:0] obsWr;

  int   cycles, pcIncN, pcBrN, bothN, regWrN, dReqN, weN;
  logic execAluOp, execSrcImm;
  bit   done;

  // Resets the DUT and the bench model, leaving the DUT idle one cycle after release.
  task automatic doReset();
    reset = 1'b0;
    run = 1'b0;
    alu_zero = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelCount = 0;
    expWrQ.delete();
    expCountQ.delete();
    @(posedge clk);
    #1;
  endtask

  // Plays the memory side for one instruction and records what the DUT did.
  // dropWhen: 0 keep run, 1 drop run in DECODE, 2 drop run during MEM.
  task automatic runInstr(input logic [7:0] word, input int imemD, input int dmemD,
                          input logic aluZ, input int dropWhen, input bit stopAtWb);
    int iw = 0;
    int dw = 0;
    bit prevInc = 0;
    logic [7:0] startCount;
    cycles = 0; pcIncN = 0; pcBrN = 0; bothN = 0; regWrN = 0; dReqN = 0; weN = 0;
    execAluOp = 1'bx; execSrcImm = 1'bx; done = 0;
    obsWrQ.delete();
    if (!stopAtWb) begin
      if (word[7:6] == 2'b00) expWrQ.push_back({word[1:0], 1'b0});
      else if (word[7:6] == 2'b01) expWrQ.push_back({word[3:2], 1'b1});
      modelCount = (modelCount + 1) % 256;
      expCountQ.push_back(8'(modelCount));
    end
    startCount = instr_count;
    for (int i = 0; i < 200; i++) begin
      if (stopAtWb && sigRegWrite) begin
        done = 1;
        break;
      end
      if (busy) cycles++;
      if (pc_inc) pcIncN++;
      if (pc_branch) pcBrN++;
      if (pc_inc && pc_branch) bothN++;
      if (sigRegWrite) begin
        regWrN++;
        obsWrQ.push_back({writeReg, wb_sel});
      end
      if (bus.dmem_req) begin
        dReqN++;
        if (bus.dmem_we) weN++;
      end
      if (prevInc) begin
        execAluOp = alu_op;
        execSrcImm = alu_src_imm;
      end
      prevInc = pc_inc;
      if (dropWhen == 1 && pc_inc) run = 1'b0;
      if (dropWhen == 2 && bus.dmem_req) run = 1'b0;
      alu_zero = aluZ;
      bus.imem_ack = 1'b0;
      bus.imem_data = 8'h00;
      bus.dmem_ack = 1'b0;
      if (bus.imem_req) begin
        if (iw >= imemD) begin
          bus.imem_ack = 1'b1;
          bus.imem_data = word;
        end else begin
          iw++;
        end
      end
      if (bus.dmem_req) begin
        if (dw >= dmemD) bus.dmem_ack = 1'b1;
        else dw++;
      end
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (instr_count != startCount) begin
        done = 1;
        break;
      end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({busy, fault, bus.imem_req, bus.dmem_req, bus.dmem_we, sigRegWrite, alu_op,
         alu_src_imm, wb_sel, pc_inc, pc_branch} !== 11'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got busy=%b fault=%b ireq=%b dreq=%b we=%b rw=%b pcinc=%b expected all 0",
               busy, fault, bus.imem_req, bus.dmem_req, bus.dmem_we, sigRegWrite, pc_inc);
    end
    testsRun++;
    if ({readReg1, readReg2, writeReg, instr_count} !== 14'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sel: got rr1=%0d rr2=%0d wr=%0d cnt=%0d expected 0",
               readReg1, readReg2, writeReg, instr_count);
    end
    run = 1'b0;
    reset = 1'b1;
    modelCount = 0;
    @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: got busy=%b ireq=%b expected 0 0", busy, bus.imem_req);
    end
  endtask

  task automatic test_add();
    doReset();
    run = 1'b1;
    runInstr(8'h1B, 0, 0, 1'b0, 1, 0);
    testsRun++;
    if (done !== 1'b1 || cycles !== 4) begin
      testsFailed++;
      $display("[TB] FAIL add_cycles: got done=%0d cycles=%0d expected 1 4", done, cycles);
    end
    testsRun++;
    if ({pcIncN, pcBrN, regWrN} !== {32'd1, 32'd0, 32'd1}) begin
      testsFailed++;
      $display("[TB] FAIL add_pulses: got inc=%0d br=%0d wr=%0d expected 1 0 1", pcIncN, pcBrN, regWrN);
    end
    testsRun++;
    if ({execAluOp, execSrcImm} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL add_exec: got aluop=%b imm=%b expected 0 0", execAluOp, execSrcImm);
    end
    testsRun++;
    if (obsWrQ.size() == 0 || expWrQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL add_wb: got %0d writes expected 1", obsWrQ.size());
    end else begin
      obsWr = obsWrQ.pop_front();
      expWr = expWrQ.pop_front();
      if (obsWr !== expWr) begin
        testsFailed++;
        $display("[TB] FAIL add_wb: got wr=%0d sel=%b expected wr=%0d sel=%b", obsWr[2:1], obsWr[0], expWr[2:1], expWr[0]);
      end
    end
    expCount = expCountQ.pop_front();
    testsRun++;
    if (instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL add_count: got %0d expected %0d", instr_count, expCount);
    end
    testsRun++;
    if ({readReg1, readReg2, busy, bus.imem_req} !== 6'b01_10_0_0) begin
      testsFailed++;
      $display("[TB] FAIL add_after: got rr1=%0d rr2=%0d busy=%b ireq=%b expected 1 2 0 0",
               readReg1, readReg2, busy, bus.imem_req);
    end
  endtask

  task automatic test_lw();
    run = 1'b1;
    runInstr(8'h46, 0, 2, 1'b0, 1, 0);
    testsRun++;
    if (done !== 1'b1 || cycles !== 7 || dReqN !== 3 || weN !== 0) begin
      testsFailed++;
      $display("[TB] FAIL lw_mem: got done=%0d cycles=%0d dreq=%0d we=%0d expected 1 7 3 0", done, cycles, dReqN, weN);
    end
    testsRun++;
    if ({execAluOp, execSrcImm} !== 2'b01 || regWrN !== 1) begin
      testsFailed++;
      $display("[TB] FAIL lw_exec: got aluop=%b imm=%b wr=%0d expected 0 1 1", execAluOp, execSrcImm, regWrN);
    end
    testsRun++;
    if (obsWrQ.size() == 0 || expWrQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL lw_wb: got %0d writes expected 1", obsWrQ.size());
    end else begin
      obsWr = obsWrQ.pop_front();
      expWr = expWrQ.pop_front();
      if (obsWr !== expWr) begin
        testsFailed++;
        $display("[TB] FAIL lw_wb: got wr=%0d sel=%b expected wr=%0d sel=%b", obsWr[2:1], obsWr[0], expWr[2:1], expWr[0]);
      end
    end
    expCount = expCountQ.pop_front();
    testsRun++;
    if (instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL lw_count: got %0d expected %0d", instr_count, expCount);
    end
  endtask

  task automatic test_sw();
    run = 1'b1;
    runInstr(8'h85, 0, 1, 1'b0, 1, 0);
    testsRun++;
    if (done !== 1'b1 || cycles !== 5 || dReqN !== 2 || weN !== 2) begin
      testsFailed++;
      $display("[TB] FAIL sw_mem: got done=%0d cycles=%0d dreq=%0d we=%0d expected 1 5 2 2", done, cycles, dReqN, weN);
    end
    testsRun++;
    if (regWrN !== 0 || expWrQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL sw_nowrite: got %0d writes expected 0", regWrN);
    end
    expCount = expCountQ.pop_front();
    testsRun++;
    if (instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL sw_count: got %0d expected %0d", instr_count, expCount);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run = 1'b1;
      runInstr(8'hF1, 0, 0, z[0], 1, 0);
      testsRun++;
      if (done !== 1'b1 || cycles !== 3 || pcIncN !== 1 || pcBrN !== z || bothN !== 0 || regWrN !== 0) begin
        testsFailed++;
        $display("[TB] FAIL beq_z%0d: got cycles=%0d inc=%0d br=%0d both=%0d wr=%0d expected 3 1 %0d 0 0",
                 z, cycles, pcIncN, pcBrN, bothN, regWrN, z);
      end
      testsRun++;
      if ({execAluOp, execSrcImm} !== 2'b10) begin
        testsFailed++;
        $display("[TB] FAIL beq_exec: got aluop=%b imm=%b expected 1 0", execAluOp, execSrcImm);
      end
      expCount = expCountQ.pop_front();
      testsRun++;
      if (instr_count !== expCount) begin
        testsFailed++;
        $display("[TB] FAIL beq_count: got %0d expected %0d", instr_count, expCount);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'h1B, 8'h46, 8'h85};
    doReset();
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      runInstr(words[k], 1, 0, 1'b0, (k == 2) ? 1 : 0, 0);
      expCount = expCountQ.pop_front();
      testsRun++;
      if (done !== 1'b1 || instr_count !== expCount) begin
        testsFailed++;
        $display("[TB] FAIL b2b_count%0d: got %0d expected %0d", k, instr_count, expCount);
      end
      while (obsWrQ.size() > 0) begin
        obsWr = obsWrQ.pop_front();
        expWr = (expWrQ.size() > 0) ? expWrQ.pop_front() : 3'bxxx;
        testsRun++;
        if (obsWr !== expWr) begin
          testsFailed++;
          $display("[TB] FAIL b2b_wb%0d: got %b expected %b", k, obsWr, expWr);
        end
      end
    end
    testsRun++;
    if (expWrQ.size() !== 0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_end: got pending=%0d busy=%b expected 0 0", expWrQ.size(), busy);
    end
  endtask

  task automatic test_timeout_boundary();
    doReset();
    run = 1'b1;
    runInstr(8'h1B, 15, 0, 1'b0, 1, 0);
    expCount = expCountQ.pop_front();
    testsRun++;
    if (done !== 1'b1 || fault !== 1'b0 || cycles !== 19 || instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL to_boundary: got done=%0d fault=%b cycles=%0d cnt=%0d expected 1 0 19 %0d",
               done, fault, cycles, instr_count, expCount);
    end
  endtask

  task automatic test_timeout_fault();
    int n = 0;
    doReset();
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (fault) break;
      if (bus.imem_req) n++;
      @(posedge clk);
      #1;
    end
    testsRun++;
    if (fault !== 1'b1 || n !== 16) begin
      testsFailed++;
      $display("[TB] FAIL to_fault: got fault=%b waitCycles=%0d expected 1 16", fault, n);
    end
    repeat (5) @(posedge clk);
    #1;
    testsRun++;
    if ({fault, busy, bus.imem_req, bus.dmem_req} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL to_sticky: got fault=%b busy=%b ireq=%b dreq=%b expected 1 0 0 0",
               fault, busy, bus.imem_req, bus.dmem_req);
    end
    reset = 1'b0;
    #1;
    testsRun++;
    if (fault !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL to_clear: got fault=%b expected 0", fault);
    end
    run = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_run_drop();
    doReset();
    run = 1'b1;
    runInstr(8'h46, 0, 3, 1'b0, 2, 0);
    expCount = expCountQ.pop_front();
    testsRun++;
    if (done !== 1'b1 || cycles !== 8 || regWrN !== 1 || instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL drop_lw: got done=%0d cycles=%0d wr=%0d cnt=%0d expected 1 8 1 %0d",
               done, cycles, regWrN, instr_count, expCount);
    end
    if (obsWrQ.size() > 0 && expWrQ.size() > 0) begin
      obsWr = obsWrQ.pop_front();
      expWr = expWrQ.pop_front();
      testsRun++;
      if (obsWr !== expWr) begin
        testsFailed++;
        $display("[TB] FAIL drop_wb: got %b expected %b", obsWr, expWr);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drop_idle: got busy=%b ireq=%b expected 0 0", busy, bus.imem_req);
    end
  endtask

  task automatic test_reset_mid_wb();
    doReset();
    run = 1'b1;
    runInstr(8'h1B, 0, 0, 1'b0, 0, 0);
    expCount = expCountQ.pop_front();
    void'(expWrQ.pop_front());
    testsRun++;
    if (instr_count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL midwb_pre: got %0d expected %0d", instr_count, expCount);
    end
    runInstr(8'h1B, 0, 0, 1'b0, 0, 1);
    testsRun++;
    if (done !== 1'b1 || sigRegWrite !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midwb_reach: got done=%0d rw=%b expected 1 1", done, sigRegWrite);
    end
    reset = 1'b0;
    #1;
    testsRun++;
    if ({sigRegWrite, busy, pc_inc, pc_branch} !== 4'b0 || instr_count !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL midwb_abort: got rw=%b busy=%b cnt=%0d expected 0 0 0", sigRegWrite, busy, instr_count);
    end
    run = 1'b0;
    reset = 1'b1;
    modelCount = 0;
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    alu_zero = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    bus.dmem_ack = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq();
    test_back_to_back();
    test_timeout_boundary();
    test_timeout_fault();
    test_run_drop();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
